// File: rtl/id_ex_stage_pkg.sv
// Shared types and widths for the ID/EX pipeline register and its operand forwarding.
package id_ex_pkg;

    localparam int DATA_W    = 16;
    localparam int REG_IDX_W = 4;

    typedef logic [DATA_W-1:0]    data_t;
    typedef logic [REG_IDX_W-1:0] regIdx_t;

    typedef enum logic [1:0] {
        FWD_RF,
        FWD_WB,
        FWD_MEM,
        FWD_EX
    } fwdSel_e;

    typedef struct packed {
        logic    valid;
        logic    regWrite;
        logic    memRead;
        regIdx_t writeReg;
        data_t   op1;
        data_t   op2;
    } exReg_t;

    localparam exReg_t EX_BUBBLE = '0;

    // Register 0 is an ordinary register, so a hit is just enable plus index equality.
    function automatic logic idxHit(input logic we, input regIdx_t wr, input regIdx_t rd);
        return we && (wr == rd);
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-side bus of the ID/EX stage: register reads, decoded control, latched EX outputs.
interface id_ex_stage_if;
    import id_ex_pkg::*;

    regIdx_t readReg1;
    regIdx_t readReg2;
    data_t   readData1;
    data_t   readData2;
    logic    inValid;
    logic    inRegWrite;
    logic    inMemRead;
    regIdx_t inWriteReg;

    logic    exValid;
    logic    exRegWrite;
    logic    exMemRead;
    regIdx_t exWriteReg;
    data_t   exOp1;
    data_t   exOp2;
    logic    hazardStall;

    modport master (
        output readReg1, readReg2, readData1, readData2,
        output inValid, inRegWrite, inMemRead, inWriteReg,
        input  exValid, exRegWrite, exMemRead, exWriteReg, exOp1, exOp2, hazardStall
    );

    modport slave (
        input  readReg1, readReg2, readData1, readData2,
        input  inValid, inRegWrite, inMemRead, inWriteReg,
        output exValid, exRegWrite, exMemRead, exWriteReg, exOp1, exOp2, hazardStall
    );

endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// One operand's forwarding select: EX > MEM > WB > register file.
module fwd_mux
    import id_ex_pkg::*;
(
    input  regIdx_t readIdx,
    input  data_t   rfData,
    input  logic    exRegWrite,
    input  regIdx_t exWriteReg,
    input  data_t   exData,
    input  logic    memRegWrite,
    input  regIdx_t memWriteReg,
    input  data_t   memData,
    input  logic    wbRegWrite,
    input  regIdx_t wbWriteReg,
    input  data_t   wbData,
    output fwdSel_e sel,
    output data_t   data
);

    always_comb begin
        sel = FWD_RF;
        if (idxHit(exRegWrite, exWriteReg, readIdx)) begin
            sel = FWD_EX;
        end else if (idxHit(memRegWrite, memWriteReg, readIdx)) begin
            sel = FWD_MEM;
        end else if (idxHit(wbRegWrite, wbWriteReg, readIdx)) begin
            sel = FWD_WB;
        end
    end

    always_comb begin
        data = rfData;
        unique case (sel)
            FWD_EX:  data = exData;
            FWD_MEM: data = memData;
            FWD_WB:  data = wbData;
            default: data = rfData;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use interlock.
// Define ID_EX_FWD_EN to enable forwarding; otherwise any in-flight writer hit interlocks.
module id_ex_stage
    import id_ex_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    id_ex_stage_if.slave  idBus,
    input  data_t         aluResult,
    input  regIdx_t       memWriteReg,
    input  logic          memRegWrite,
    input  data_t         memResult,
    input  regIdx_t       wbWriteReg,
    input  logic          wbRegWrite,
    input  data_t         wbData,
    input  logic          stall,
    input  logic          flush
);

    exReg_t  exReg;
    logic    exWriter;
    fwdSel_e sel1;
    fwdSel_e sel2;
    data_t   fwdData1;
    data_t   fwdData2;
    data_t   op1;
    data_t   op2;
    logic    hazard;

    assign exWriter = exReg.valid && exReg.regWrite;

    fwd_mux u_fwd1 (
        .readIdx     (idBus.readReg1),
        .rfData      (idBus.readData1),
        .exRegWrite  (exWriter),
        .exWriteReg  (exReg.writeReg),
        .exData      (aluResult),
        .memRegWrite (memRegWrite),
        .memWriteReg (memWriteReg),
        .memData     (memResult),
        .wbRegWrite  (wbRegWrite),
        .wbWriteReg  (wbWriteReg),
        .wbData      (wbData),
        .sel         (sel1),
        .data        (fwdData1)
    );

    fwd_mux u_fwd2 (
        .readIdx     (idBus.readReg2),
        .rfData      (idBus.readData2),
        .exRegWrite  (exWriter),
        .exWriteReg  (exReg.writeReg),
        .exData      (aluResult),
        .memRegWrite (memRegWrite),
        .memWriteReg (memWriteReg),
        .memData     (memResult),
        .wbRegWrite  (wbRegWrite),
        .wbWriteReg  (wbWriteReg),
        .wbData      (wbData),
        .sel         (sel2),
        .data        (fwdData2)
    );

`ifdef ID_EX_FWD_EN
    // Only a load in EX cannot be forwarded: its data is not ready until MEM.
    assign op1    = fwdData1;
    assign op2    = fwdData2;
    assign hazard = idBus.inValid && exReg.memRead
                    && ((sel1 == FWD_EX) || (sel2 == FWD_EX));
`else
    // Without forwarding the select is reused purely as an "in-flight writer hit" detector.
    logic unusedFwdData;
    assign unusedFwdData = ^{fwdData1, fwdData2};
    assign op1    = idBus.readData1;
    assign op2    = idBus.readData2;
    assign hazard = idBus.inValid && ((sel1 != FWD_RF) || (sel2 != FWD_RF));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            exReg <= '0;
        end else if (flush) begin
            exReg <= EX_BUBBLE;
        end else if (!stall) begin
            if (hazard || !idBus.inValid) begin
                exReg <= EX_BUBBLE;
            end else begin
                exReg <= '{valid:    1'b1,
                           regWrite: idBus.inRegWrite,
                           memRead:  idBus.inMemRead,
                           writeReg: idBus.inWriteReg,
                           op1:      op1,
                           op2:      op2};
            end
        end
    end

    assign idBus.hazardStall = hazard;
    assign idBus.exValid     = exReg.valid;
    assign idBus.exRegWrite  = exReg.regWrite;
    assign idBus.exMemRead   = exReg.memRead;
    assign idBus.exWriteReg  = exReg.writeReg;
    assign idBus.exOp1       = exReg.op1;
    assign idBus.exOp2       = exReg.op2;

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have clk  input  1  rising-edge clock.
REQ-002 SHALL have rst  input  1  reset; one clock, reset synchronous and active-high.
REQ-003 SHALL have readReg1, readReg2  input  4 each  source register indices sent to the register file.
REQ-004 SHALL have readData1, readData2  input  16 each  register file read data; the register file has no internal write-to-read bypass.
REQ-005 SHALL have inValid, inRegWrite, inMemRead  input  1 each  decoded instruction valid, writes a register, is a load.
REQ-006 SHALL have inWriteReg  input  4  destination register index.
REQ-007 SHALL have exRegWrite, exMemRead, exValid  output  1 each  latched control for EX.
REQ-008 SHALL have exWriteReg  output  4  latched destination.
REQ-009 SHALL have exOp1, exOp2  output  16 each  latched, forwarded operands.
REQ-010 SHALL have aluResult  input  16  combinational ALU result of the instruction currently in EX.
REQ-011 SHALL have memWriteReg (4), memRegWrite (1), memResult (16)  input  MEM-stage writer.
REQ-012 SHALL have wbWriteReg (4), wbRegWrite (1), wbData (16)  input  WB-stage writer (same port values driven into the register file).
REQ-013 SHALL have stall, flush  input  1 each  external hold and kill.
REQ-014 SHALL have hazardStall  output  1  combinational; instructs IF/ID to hold.

Function
REQ-015 Operand source per operand SHALL be chosen with priority EX > MEM > WB > register file; a source matches when its RegWrite is 1 and its WriteReg equals the read index (EX source uses exWriteReg/exRegWrite with exValid=1).
REQ-016 Register index 0 SHALL be treated as an ordinary register (no zero special case).
REQ-017 hazardStall SHALL be 1 when inValid=1, exValid=1, exMemRead=1, exRegWrite=1 and exWriteReg equals readReg1 or readReg2; else 0.
REQ-018 Per rising edge, priority SHALL be: flush -> load bubble; else stall -> hold all outputs; else hazardStall -> load bubble; else capture inputs with forwarded operands.
REQ-019 A bubble SHALL set exValid, exRegWrite, exMemRead to 0 and exWriteReg, exOp1, exOp2 to 0.
REQ-020 Capture latency SHALL be one cycle; outputs change only on clk edges.
REQ-021 inValid=0 captured SHALL produce a bubble regardless of other inputs.
REQ-022 Simultaneous stall and hazardStall SHALL hold (stall wins); flush overrides both.

Reset
REQ-023 When rst=1 at a rising edge, all registered outputs SHALL become 0, overriding flush and stall.
REQ-024 Reset mid-stall SHALL discard the held instruction; first post-reset capture proceeds normally.

Configuration
REQ-025 With ID_EX_FWD_EN defined, forwarding per REQ-015 and hazard per REQ-017 SHALL apply.
REQ-026 Without ID_EX_FWD_EN, operands SHALL come only from readData1/2, and hazardStall SHALL assert whenever inValid=1 and any valid writer in EX, MEM or WB has RegWrite=1 and WriteReg equal to readReg1 or readReg2.

Structure
REQ-027 Package id_ex_pkg SHALL hold DATA_W=16, REG_IDX_W=4 and the forward-select enum {FWD_RF, FWD_WB, FWD_MEM, FWD_EX}.
REQ-028 Sub-module fwd_mux SHALL implement one operand's match/priority select; id_ex_stage instantiates it twice.

Verification
REQ-029 Reset: rst=1 one cycle with stall=1 -> all outputs 0 next cycle.
REQ-030 Forward priority: readReg1=3, EX, MEM, WB all write R3 with aluResult=16'h1111, memResult=16'h2222, wbData=16'h3333 -> exOp1=16'h1111; drop EX writer -> 16'h2222; drop MEM -> 16'h3333; drop WB -> readData1.
REQ-031 Load-use: EX is load to R5, readReg2=5 -> hazardStall=1, next exValid=0; next cycle, load moved to MEM with memResult=16'hBEEF -> exOp2=16'hBEEF.
REQ-032 Stall/flush: capture exOp1=16'h00AA, then stall=1 for 3 cycles with new inputs -> exOp1 stays 16'h00AA; stall=1 and flush=1 together -> bubble.
REQ-033 Write-read same cycle: wbRegWrite=1, wbWriteReg=7, wbData=16'h1234, readReg1=7, readData1=16'h0000 -> exOp1=16'h1234.
REQ-034 Macro off: repeat REQ-033 stimulus -> hazardStall=1, bubble captured; next cycle with WB retired -> exOp1=readData1.
